// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - two-entry skid buffer pipeline stage with bubble counter
module pipe_stage_buf #(
  parameter int          PAYLOAD_W = 96,
  parameter logic [31:0] RESET_PC  = 32'h00003000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000,
  parameter int          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_instr,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_instr,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t               r_state;
  logic [31:0]          r_head_pc;
  logic [31:0]          r_head_instr;
  logic [PAYLOAD_W-1:0] r_head_payload;
  logic [31:0]          r_skid_pc;
  logic [31:0]          r_skid_instr;
  logic [PAYLOAD_W-1:0] r_skid_payload;
  logic [CNT_W-1:0]     r_bubble_cnt;

  logic                 w_push;
  logic                 w_pop;

  // Handshake outputs decode registered state only, so upstream ready never
  // depends combinationally on downstream ready.
  assign in_ready    = (r_state != ST_FULL);
  assign out_valid   = (r_state != ST_EMPTY);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;

  assign out_pc      = r_head_pc;
  assign out_instr   = r_head_instr;
  assign out_payload = r_head_payload;
  assign bubble_cnt  = r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_EMPTY;
      r_head_pc      <= RESET_PC;
      r_head_instr   <= NOP_INSTR;
      r_head_payload <= '0;
      r_skid_pc      <= RESET_PC;
      r_skid_instr   <= NOP_INSTR;
      r_skid_payload <= '0;
      r_bubble_cnt   <= '0;
    end else begin
      if ((r_state == ST_EMPTY) && (r_bubble_cnt != {CNT_W{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end

      if (flush) begin
        r_state        <= ST_EMPTY;
        r_head_pc      <= RESET_PC;
        r_head_instr   <= NOP_INSTR;
        r_head_payload <= '0;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_push) begin
              r_head_pc      <= in_pc;
              r_head_instr   <= in_instr;
              r_head_payload <= in_payload;
              r_state        <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (w_push && w_pop) begin
              r_head_pc      <= in_pc;
              r_head_instr   <= in_instr;
              r_head_payload <= in_payload;
            end else if (w_push) begin
              r_skid_pc      <= in_pc;
              r_skid_instr   <= in_instr;
              r_skid_payload <= in_payload;
              r_state        <= ST_FULL;
            end else if (w_pop) begin
              r_state        <= ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (w_pop) begin
              r_head_pc      <= r_skid_pc;
              r_head_instr   <= r_skid_instr;
              r_head_payload <= r_skid_payload;
              r_state        <= ST_ONE;
            end
          end
          default: begin
            r_state <= ST_EMPTY;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 96, width of the stage-specific payload bus (e.g. aluRet, rt, RD, ext concatenated).
REQ-002 SHALL have parameter RESET_PC, default 32'h00003000, PC value loaded on reset/flush.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h00000000, instruction word loaded on reset/flush.
REQ-004 SHALL have parameter CNT_W, default 16, bubble counter width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous pipeline flush; discards all held entries.
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_pc  input  32  upstream PC.
REQ-011 in_instr  input  32  upstream instruction word.
REQ-012 in_payload  input  PAYLOAD_W  upstream payload.
REQ-013 out_valid  output  1  out_* fields hold a valid entry.
REQ-014 out_ready  input  1  downstream accepts the entry.
REQ-015 out_pc, out_instr  output  32 each  head-entry PC and instruction.
REQ-016 out_payload  output  PAYLOAD_W  head-entry payload.
REQ-017 bubble_cnt  output  CNT_W  saturating count of cycles with out_valid=0.

Function
REQ-018 SHALL be a 2-entry skid buffer: head register (drives out_*) and skid register; state EMPTY, ONE, FULL.
REQ-019 push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-020 in_ready SHALL equal (state != FULL), decoded from registered state only; no combinational path from out_ready or in_valid.
REQ-021 out_valid SHALL equal (state != EMPTY).
REQ-022 EMPTY: push -> head<=in, ONE; else stay.
REQ-023 ONE: push&pop -> head<=in, stay ONE; push&!pop -> skid<=in, FULL; !push&pop -> EMPTY; neither -> stay.
REQ-024 FULL: pop -> head<=skid, ONE; else stay; in_valid ignored.
REQ-025 Latency SHALL be 1 cycle: entry pushed at edge N visible on out_* after edge N when head was empty or popped.
REQ-026 Throughput SHALL be 1 entry/cycle while out_ready=1; entries SHALL leave in push order, none lost or duplicated.
REQ-027 On pop to EMPTY head fields SHALL hold last values; only out_valid drops.
REQ-028 All fields (pc, instr, payload) SHALL move together; no per-field skew.
REQ-029 flush=1 SHALL override push/pop: state<=EMPTY, head pc<=RESET_PC, instr<=NOP_INSTR, payload<=0; skid contents don't-care; concurrent in_valid dropped.
REQ-030 flush SHALL NOT alter bubble_cnt except the normal increment rule.
REQ-031 bubble_cnt SHALL increment by 1 at each edge where out_valid=0 before the edge and reset=0; saturates at all-ones, never wraps.

Reset
REQ-032 reset=1 at an edge SHALL set state EMPTY, out_valid=0, in_ready=1, out_pc=RESET_PC, out_instr=NOP_INSTR, out_payload=0, bubble_cnt=0.
REQ-033 reset SHALL take priority over flush and handshake; mid-operation reset discards both entries.
REQ-034 First push SHALL be accepted in the cycle reset deasserts.

Verification
REQ-035 Reset then idle 3 cycles -> out_valid=0, in_ready=1, out_pc=32'h00003000, out_instr=0, bubble_cnt=3.
REQ-036 Stream pc 0x3000,0x3004,0x3008 with out_ready=1 each cycle -> same pcs on out_pc one cycle later, back-to-back, in_ready stays 1.
REQ-037 out_ready=0, push A,B -> FULL, in_ready=0, C held upstream; out_ready=1 -> A, B, C emerge in order, no drop.
REQ-038 FULL with A,B; assert flush with in_valid=1 (D) -> next cycle out_valid=0, out_pc=0x3000, out_instr=0; A, B, D never appear.
REQ-039 Hold out_valid=0 for 2^CNT_W+5 cycles -> bubble_cnt saturates at all-ones, does not wrap.
REQ-040 Reset asserted while FULL with flush=1 -> all outputs at reset values, bubble_cnt=0 next cycle.
